// File: rtl/gzip_block_sequencer.sv
// rtl/gzip_block_sequencer.sv - splits a byte stream into DEFLATE blocks for the gzip_top input FIFO (optional: GZIP_SEQ_STATS_EN)
module gzip_block_sequencer #(
  parameter int MAX_BLOCK_LEN = 65535,
  parameter int LEN_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] cfg_total_len,
  input  logic [1:0]           cfg_btype,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 full_in_fifo,
  output logic                 wr_en_fifo_in,
  output logic [31:0]          din_fifo_in,
  output logic [1:0]           btype_in,
  output logic                 busy,
  output logic                 done
`ifdef GZIP_SEQ_STATS_EN
  ,
  output logic [15:0]          stat_blocks,
  output logic [31:0]          stat_words
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_BLOCK_LEN);

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [23:0]          blk_cnt_q, blk_cnt_d;
  logic [1:0]           lane_q, lane_d;
  logic [31:0]          word_q, word_d;
  logic                 pend_q, pend_d;
  logic [1:0]           btype_q, btype_d;

  logic                 accept;
  logic                 bfinal;
  logic [LEN_WIDTH-1:0] blk_len_full;
  logic [23:0]          blk_len;
  logic [31:0]          hdr_word;
  logic                 wr_fire;
  logic                 byte_fire;

  // Block sizing and header word derived from the bytes still to send
  always_comb begin
    bfinal       = (remaining_q <= MAX_L);
    blk_len_full = bfinal ? remaining_q : MAX_L;
    blk_len      = 24'(blk_len_full);
    hdr_word     = {blk_len[7:0], blk_len[15:8], blk_len[23:16], 7'b0, bfinal};
  end

  // A start is honoured only when no job is running
  assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  // The pending word is written the first cycle the FIFO has room
  assign wr_fire   = pend_q && !full_in_fifo;
  assign s_ready   = (state_q == S_DATA) && !pend_q;
  assign byte_fire = s_ready && s_valid;

  assign wr_en_fifo_in = wr_fire;
  assign din_fifo_in   = word_q;
  assign btype_in      = btype_q;
  assign busy          = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_FLUSH);
  assign done          = (state_q == S_DONE);

  // Next-state logic: header emission, byte packing and word hand-off
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    blk_cnt_d   = blk_cnt_q;
    lane_d      = lane_q;
    word_d      = word_q;
    pend_d      = pend_q;
    btype_d     = btype_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          remaining_d = cfg_total_len;
          btype_d     = cfg_btype;
          pend_d      = 1'b0;
          state_d     = S_HDR;
        end
      end

      S_HDR: begin
        if (!pend_q) begin
          word_d = hdr_word;
          pend_d = 1'b1;
        end else if (wr_fire) begin
          pend_d      = 1'b0;
          remaining_d = remaining_q - blk_len_full;
          blk_cnt_d   = blk_len;
          lane_d      = 2'd0;
          state_d     = (blk_len == 24'd0) ? S_DONE : S_DATA;
        end
      end

      S_DATA: begin
        if (pend_q) begin
          if (wr_fire) begin
            pend_d = 1'b0;
            lane_d = 2'd0;
            if (blk_cnt_q == 24'd0) begin
              state_d = (remaining_q != '0) ? S_HDR : S_DONE;
            end
          end else begin
            state_d = S_FLUSH;
          end
        end else if (byte_fire) begin
          // Lane 0 starts a fresh word so unused upper lanes read as zero
          if (lane_q == 2'd0) begin
            word_d = 32'd0;
          end
          word_d[{lane_q, 3'b000} +: 8] = s_data;
          blk_cnt_d = blk_cnt_q - 24'd1;
          lane_d    = lane_q + 2'd1;
          if ((lane_q == 2'd3) || (blk_cnt_q == 24'd1)) begin
            pend_d = 1'b1;
          end
        end
      end

      S_FLUSH: begin
        if (wr_fire) begin
          pend_d = 1'b0;
          lane_d = 2'd0;
          if (blk_cnt_q != 24'd0) begin
            state_d = S_DATA;
          end else begin
            state_d = (remaining_q != '0) ? S_HDR : S_DONE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial word
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      blk_cnt_q   <= 24'd0;
      lane_q      <= 2'd0;
      word_q      <= 32'd0;
      pend_q      <= 1'b0;
      btype_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      blk_cnt_q   <= blk_cnt_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      pend_q      <= pend_d;
      btype_q     <= btype_d;
    end
  end

`ifdef GZIP_SEQ_STATS_EN
  logic [15:0] stat_blocks_q;
  logic [31:0] stat_words_q;

  // Saturating counts of headers and of all FIFO writes for the current job
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      stat_blocks_q <= 16'd0;
      stat_words_q  <= 32'd0;
    end else if (wr_fire) begin
      if (stat_words_q != 32'hFFFF_FFFF) begin
        stat_words_q <= stat_words_q + 32'd1;
      end
      if ((state_q == S_HDR) && (stat_blocks_q != 16'hFFFF)) begin
        stat_blocks_q <= stat_blocks_q + 16'd1;
      end
    end
  end

  assign stat_blocks = stat_blocks_q;
  assign stat_words  = stat_words_q;
`endif

endmodule

// File: doc/gzip_block_sequencer.md
Name: gzip_block_sequencer

Overview:
- Host-side controller that feeds the gzip_top input FIFO.
- Takes a byte stream of known total length and splits it into DEFLATE blocks of at most MAX_BLOCK_LEN bytes.
- For each block it writes one header word (BFINAL + 24-bit length), then the block's bytes packed little-endian into 32-bit words, obeying full_in_fifo.
- It also drives btype_in to gzip_top.

Parameters:
- MAX_BLOCK_LEN, 65535, maximum bytes per block; legal range 1..2^24-1.
- LEN_WIDTH, 32, width of the total-length counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a job; ignored while busy=1
- cfg_total_len  in  LEN_WIDTH  total job bytes, latched on accepted start
- cfg_btype  in  2  block type, latched on accepted start
- s_data  in  8  input byte
- s_valid  in  1  s_data valid
- s_ready  out  1  byte accepted when s_valid and s_ready are both high at a clk edge
- full_in_fifo  in  1  gzip_top input FIFO full
- wr_en_fifo_in  out  1  FIFO write strobe
- din_fifo_in  out  32  FIFO write data
- btype_in  out  2  latched block type to gzip_top
- busy  out  1  job in progress
- done  out  1  one-cycle pulse after the job's last FIFO write

Behaviour:
- Reset values: s_ready=0, wr_en_fifo_in=0, din_fifo_in=0, btype_in=0, busy=0, done=0, all counters 0, state IDLE.
- Reset asserted mid-job aborts it. Partial words are discarded and no done pulse is issued.
- States: IDLE, HDR, DATA, FLUSH, DONE.
- IDLE:
  - start latches cfg_total_len into remaining and cfg_btype into btype_in.
  - Sets busy=1 and goes to HDR.
- HDR:
  - blk_len = min(remaining, MAX_BLOCK_LEN).
  - BFINAL = 1 iff remaining <= MAX_BLOCK_LEN.
  - Header word layout: din[7:0]={7'b0,BFINAL}, din[15:8]=blk_len[23:16], din[23:16]=blk_len[15:8], din[31:24]=blk_len[7:0].
  - Written when full_in_fifo=0, i.e. wr_en_fifo_in=1 for exactly one cycle with registered data.
  - After the write: remaining -= blk_len, blk_cnt = blk_len; go to DATA, or to DONE if blk_len=0.
- DATA:
  - s_ready = 1 while no word is pending.
  - Each accepted byte goes into lane k (0..3) as din[8k+7:8k]; the first byte of a word goes in lane 0. blk_cnt decrements per byte.
  - A word becomes pending when lane 3 fills or blk_cnt reaches 0. Unused upper lanes are 0.
  - While a word is pending, s_ready=0. It is written on the first cycle with full_in_fifo=0.
  - After a write with blk_cnt=0: go to HDR if remaining>0, else to DONE.
- FLUSH: used only to hold a pending word while full_in_fifo=1. It returns to DATA (or proceeds to HDR/DONE) on the write.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Zero-length job (cfg_total_len=0): one header 0x00000001 (BFINAL=1, length 0), then done.
- Each block's data starts on a new word; the tail of a block is never packed with the next block's bytes.
- wr_en_fifo_in is never asserted when full_in_fifo=1.
- Byte throughput: at most 4 bytes per 5 cycles.
- s_valid=0 simply stalls the sequencer; there is no timeout.

Optional Feature:
- Macro: GZIP_SEQ_STATS_EN.
- Defined: adds outputs stat_blocks[15:0] (headers written) and stat_words[31:0] (all FIFO writes).
  - Both clear on rst or on an accepted start.
  - Both saturate at all-ones.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Default params, start with cfg_total_len=39, cfg_btype=2'b01, bytes "Ana are mere. Ovidiu are mere mere Ana." with FIFO never full -> 11 writes:
  - first write 0x27000001;
  - second write 0x20616E41;
  - last write 0x002E616E;
  - then one done pulse; btype_in=2'b01.
- MAX_BLOCK_LEN=16, cfg_total_len=39 -> headers 0x10000000, 0x10000000, 0x07000001, each followed by 4, 4 and 2 data words. 13 writes total.
- cfg_total_len=0 -> single write 0x00000001, then done; s_ready never asserts.
- Hold full_in_fifo=1 for 10 cycles while a word is pending -> no wr_en_fifo_in and s_ready=0 during the stall. Exact word written on the first non-full cycle; no data lost or duplicated.
- Pulse start during a busy job, then assert rst after 5 data bytes -> the second start is ignored. After rst, all outputs are at reset values, busy=0 and no done pulse. A new job with cfg_total_len=4 writes 0x04000001 plus one data word.
- GZIP_SEQ_STATS_EN defined, second test case (MAX_BLOCK_LEN=16, cfg_total_len=39) -> stat_blocks=3 and stat_words=13 at done.
